// File: rtl/pkt_serializer.sv
// pkt_serializer: USB TX packet serializer with SYNC prefix, built-in bit stuffing and counted EOP.
// The SYNC literal is transmitted left to right (0000000 then 1) so it ends in a 1 that feeds the stuff run.
module pkt_serializer #(
  parameter int MAX_BYTES = 11,
  parameter logic [7:0] SYNC = 8'b0000_0001,
  parameter int STUFF_RUN = 6,
  parameter int EOP_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           pkt_valid,
  input  logic [$clog2(MAX_BYTES+1)-1:0] pkt_len,
  input  logic [8*MAX_BYTES-1:0]         pkt_data,
  output logic                           pkt_ready,
  output logic                           bit_valid,
  output logic                           bit_out,
  input  logic                           bit_ready,
  output logic                           stuffed,
  output logic                           eop,
  output logic                           done,
  output logic                           busy
);
  localparam int LW = $clog2(MAX_BYTES+1);
  localparam int BW = $clog2(8*MAX_BYTES+1);
  localparam int RW = $clog2(STUFF_RUN+1);
  localparam int EW = $clog2(EOP_CYCLES+1);
  typedef enum logic [1:0] {IDLE, SYNC_TX, DATA_TX, EOP_TX} state_t;
  state_t                 r_state;
  logic [8*MAX_BYTES-1:0] r_shift;
  logic [7:0]             r_sync;
  logic [2:0]             r_sync_left;
  logic [BW-1:0]          r_bits;
  logic [RW-1:0]          r_run;
  logic [EW-1:0]          r_eop_cnt;
  logic                   r_bit_valid, r_bit_out, r_stuffed, r_eop, r_done;
  logic [LW-1:0]          w_len;
  logic [RW-1:0]          w_run;
  assign w_len = (pkt_len > LW'(MAX_BYTES)) ? LW'(MAX_BYTES) : pkt_len;
  // run length including the bit being transferred now; a stuffed bit is a 0 and clears it
  assign w_run = r_bit_out ? r_run + 1'b1 : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_sync      <= '0;
      r_sync_left <= '0;
      r_bits      <= '0;
      r_run       <= '0;
      r_eop_cnt   <= '0;
      r_bit_valid <= 1'b0;
      r_bit_out   <= 1'b0;
      r_stuffed   <= 1'b0;
      r_eop       <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: if (pkt_valid) begin
          r_state     <= SYNC_TX;
          r_shift     <= pkt_data;
          r_bits      <= BW'({w_len, 3'b000});
          r_sync      <= {SYNC[6:0], 1'b0};
          r_sync_left <= 3'd7;
          r_run       <= '0;
          r_bit_out   <= SYNC[7];
          r_bit_valid <= 1'b1;
          r_stuffed   <= 1'b0;
        end
        SYNC_TX, DATA_TX: if (bit_ready) begin
          r_run     <= w_run;
          r_stuffed <= 1'b0;
          if (w_run == RW'(STUFF_RUN)) begin
            r_bit_out <= 1'b0;
            r_stuffed <= 1'b1;
          end else if (r_sync_left != 3'd0) begin
            r_bit_out   <= r_sync[7];
            r_sync      <= r_sync << 1;
            r_sync_left <= r_sync_left - 1'b1;
          end else if (r_bits != '0) begin
            r_state   <= DATA_TX;
            r_bit_out <= r_shift[0];
            r_shift   <= r_shift >> 1;
            r_bits    <= r_bits - 1'b1;
          end else begin
            r_state     <= EOP_TX;
            r_bit_valid <= 1'b0;
            r_bit_out   <= 1'b0;
            r_eop       <= 1'b1;
            r_eop_cnt   <= '0;
          end
        end
        EOP_TX: if (bit_ready) begin
          if (r_eop_cnt == EW'(EOP_CYCLES-1)) begin
            r_state <= IDLE;
            r_eop   <= 1'b0;
            r_done  <= 1'b1;
          end else
            r_eop_cnt <= r_eop_cnt + 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  assign pkt_ready = r_state == IDLE;
  assign busy      = r_state != IDLE;
  assign bit_valid = r_bit_valid;
  assign bit_out   = r_bit_out;
  assign stuffed   = r_stuffed;
  assign eop       = r_eop;
  assign done      = r_done;
endmodule

// File: tb/tb_pkt_serializer.sv
// tb_pkt_serializer: random and directed packets scored against a bit-list reference model.
module tb_pkt_serializer;
  localparam int MB = 11;
  localparam int SR = 6;
  localparam int EC = 2;
  localparam logic [7:0] SY = 8'b0000_0001;
  localparam int LW = $clog2(MB+1);
  logic clk = 1'b0, rst = 1'b1, pkt_valid = 1'b0, bit_ready = 1'b0;
  logic [LW-1:0] pkt_len = '0;
  logic [8*MB-1:0] pkt_data = '0;
  logic pkt_ready, bit_valid, bit_out, stuffed, eop, done, busy;
  typedef struct {logic d; logic b; logic s; logic t; int cyc;} exp_t;
  exp_t q[$];
  int cyc = 0, total = 0, passed = 0, mode = 0;
  pkt_serializer #(.MAX_BYTES(MB), .SYNC(SY), .STUFF_RUN(SR), .EOP_CYCLES(EC)) dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .pkt_len(pkt_len), .pkt_data(pkt_data),
    .pkt_ready(pkt_ready), .bit_valid(bit_valid), .bit_out(bit_out), .bit_ready(bit_ready),
    .stuffed(stuffed), .eop(eop), .done(done), .busy(busy));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial forever begin
    @(posedge clk);
    #1;
    bit_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ~bit_ready : ($urandom_range(0, 3) != 0);
  end
  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: cycle %0d reached without finishing", cyc);
    $fatal(1, "timeout");
  end
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, a, e, cyc);
  endtask
  function automatic logic [8*MB-1:0] rnd();
    logic [8*MB-1:0] r;
    for (int i = 0; i < MB; i++) r[8*i+:8] = 8'($urandom);
    return r;
  endfunction
  // expected line stream: SYNC left to right, payload LSB first, a 0 after every run of SR ones
  task automatic model(input int len, input logic [8*MB-1:0] d);
    logic [7:0] sy = SY;
    logic bits[$];
    int run = 0, n = 0;
    int nb = (len > MB ? MB : len) * 8;
    for (int i = 7; i >= 0; i--) bits.push_back(sy[i]);
    for (int i = 0; i < nb; i++) bits.push_back(d[i]);
    foreach (bits[i]) begin
      q.push_back('{1'b0, bits[i], 1'b0, 1'b0, 0});
      n++;
      run = bits[i] ? run + 1 : 0;
      if (run == SR) begin
        q.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 0});
        n++;
        run = 0;
      end
    end
    q.push_back('{1'b1, 1'b0, 1'b0, mode == 0, cyc + n + EC + 1});
  endtask
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic send(input int len, input logic [8*MB-1:0] d);
    int w = 0;
    while (!pkt_ready && w < 3000) begin step(); w++; end
    chk("accept_wait", pkt_ready, 1);
    pkt_valid = 1'b1;
    pkt_len = LW'(len);
    pkt_data = d;
    model(len, d);
    step();
    pkt_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int w = 0;
    while ((q.size() != 0 || !pkt_ready) && w < 5000) begin step(); w++; end
    chk("drain", q.size(), 0);
  endtask
  initial begin
    int rc = 0;
    logic hv = 1'b0, hb = 1'b0, hs = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        rc = 0;
        hv = 1'b0;
      end else begin
        if (hv) chk("hold", {bit_valid, bit_out, stuffed}, {1'b1, hb, hs});
        hv = bit_valid && !bit_ready;
        hb = bit_out;
        hs = stuffed;
        chk("busy", busy, !pkt_ready);
        if (eop) chk("eop_no_bit", bit_valid, 0);
        if (eop && bit_ready) rc++;
        if (bit_valid && bit_ready) begin
          chk("stream_avail", q.size() > 0 && !q[0].d, 1);
          if (q.size() > 0 && !q[0].d) begin
            e = q.pop_front();
            chk("bit_out", bit_out, e.b);
            chk("stuffed", stuffed, e.s);
          end
        end
        if (done) begin
          chk("done_avail", q.size() > 0 && q[0].d, 1);
          if (q.size() > 0 && q[0].d) begin
            e = q.pop_front();
            chk("eop_ready_cycles", rc, EC);
            chk("done_ready", pkt_ready, 1);
            if (e.t) chk("done_cycle", cyc, e.cyc);
          end
          rc = 0;
        end
      end
    end
  end
  initial begin
    logic [8*MB-1:0] d;
    repeat (2) step();
    chk("rst_outs", {pkt_ready, bit_valid, bit_out, stuffed, eop, done, busy}, 7'b1000000);
    rst = 1'b0;
    step();
    d = '0; d[7:0] = 8'hA5; send(1, d); wait_idle();
    d = '0; d[7:0] = 8'hFF; send(1, d); wait_idle();
    d = '0; d[7:0] = 8'hFC; send(1, d); wait_idle();
    mode = 1;
    d = '0; d[15:0] = 16'h1234; send(2, d); wait_idle();
    mode = 0;
    step();
    send(3, rnd());
    repeat (9) step();
    rst = 1'b1;
    #1;
    chk("rst_mid", {pkt_ready, bit_valid, bit_out, stuffed, eop, done, busy}, 7'b1000000);
    q.delete();
    step();
    rst = 1'b0;
    send(0, rnd()); wait_idle();
    send(15, rnd());
    repeat (5) begin
      step();
      pkt_valid = 1'b1;
      pkt_data = rnd();
      pkt_len = LW'($urandom_range(0, 15));
      step();
      pkt_valid = 1'b0;
    end
    for (int w = 0; w < 3000 && !pkt_ready; w++) step();
    chk("b2b_done", done, 1);
    send(2, rnd()); wait_idle();
    mode = 2;
    repeat (15) begin
      send($urandom_range(0, 15), rnd());
      if ($urandom_range(0, 1) != 0) wait_idle();
    end
    wait_idle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
